// File: rtl/accum_carry.sv
// WIDTH-bit registered accumulator on a ripple chain of propagate/generate carry cells.
// Define ACCUM_SATURATE_EN to get unsigned saturation on accumulate; it wraps by default.
module accum_carry #(
  parameter int unsigned           WIDTH      = 16,
  parameter logic [WIDTH-1:0]      INIT_VALUE = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             LOAD,
  input  logic             SUB,
  input  logic             CIN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] acc_q;

  // Subtract is Q + ~D + 1; CIN then acts as an extra borrow.
  assign b    = SUB ? ~D : D;
  assign c[0] = CIN ^ SUB;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign p[i]   = Q[i] ^ b[i];
    assign g[i]   = Q[i] & b[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = p[i] ? c[i] : g[i];
  end

  always_comb begin
    acc_q = s;
`ifdef ACCUM_SATURATE_EN
    if (!SUB && c[WIDTH]) begin
      acc_q = '1;
    end else if (SUB && !c[WIDTH]) begin
      acc_q = '0;
    end
`endif
  end

  always_ff @(posedge C) begin
    if (R) begin
      Q    <= INIT_VALUE;
      COUT <= 1'b0;
      OVF  <= 1'b0;
    end else if (LOAD) begin
      Q    <= D;
      COUT <= 1'b0;
      OVF  <= 1'b0;
    end else if (E) begin
      Q    <= acc_q;
      COUT <= c[WIDTH];
      OVF  <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

  assign ZERO = (Q == '0);

endmodule
